// File: rtl/multi_clock_generation.sv
// Multi-channel programmable clock generator: per channel an unpausable level,
// a pausable copy that pauses/resumes only on phase boundaries, and edge strobes.
package clks_alot_p;
  localparam int unsigned RATE_COUNTER_WIDTH = 8;
endpackage

package common_p;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;
endpackage

module multi_clock_generation #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned RATE_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH
) (
  input  common_p::clk_dom_s                    sys_dom_i,
  input  logic                                  async_rst_i,
  input  logic [CHANNELS-1:0]                   generation_en_i,
  input  logic [CHANNELS-1:0]                   init_i,
  input  logic [CHANNELS-1:0]                   starting_polarity_i,
  input  logic [CHANNELS-1:0][RATE_WIDTH-1:0]   phase_offset_i,
  input  logic [CHANNELS-1:0][RATE_WIDTH-1:0]   high_rate_i,
  input  logic [CHANNELS-1:0][RATE_WIDTH-1:0]   low_rate_i,
  input  logic [CHANNELS-1:0]                   pause_en_i,
  input  logic [CHANNELS-1:0]                   pause_polarity_i,
  output logic [CHANNELS-1:0]                   clk_o,
  output logic [CHANNELS-1:0]                   pausable_clk_o,
  output logic [CHANNELS-1:0]                   rising_o,
  output logic [CHANNELS-1:0]                   falling_o,
  output logic [CHANNELS-1:0]                   paused_o,
  output logic [CHANNELS-1:0]                   rate_zero_violation_o,
  output logic [CHANNELS-1:0]                   pause_start_violation_o,
  output logic [CHANNELS-1:0]                   pause_stop_violation_o
);

  typedef enum logic [1:0] {
    ACTIVE,
    PAUSE_PENDING,
    PAUSED,
    RESUME_PENDING
  } pause_state_e;

  localparam logic [RATE_WIDTH-1:0] RATE_ONE = RATE_WIDTH'(1);

  logic clk;
  logic clk_en;
  logic unused_sync_rst;

  assign clk             = sys_dom_i.clk;
  assign clk_en          = sys_dom_i.clk_en;
  assign unused_sync_rst = sys_dom_i.sync_rst;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0] rate;
    logic                  lvl_q, lvl_d;
    logic                  pclk_q, pclk_d;
    pause_state_e          state_q, state_d;
    logic                  pause_q;
    logic                  paused_q;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  rz_q, rz_d;
    logic                  pstart_q, pstart_d;
    logic                  pstop_q, pstop_d;
    logic                  toggle;
    logic                  new_lvl;
    logic                  pause_rise;
    logic                  pause_fall;

    always_comb begin
      toggle     = generation_en_i[ch] && (cnt_q == '0) && !init_i[ch];
      new_lvl    = ~lvl_q;
      rate       = new_lvl ? high_rate_i[ch] : low_rate_i[ch];
      pause_rise = pause_en_i[ch] & ~pause_q;
      pause_fall = ~pause_en_i[ch] & pause_q;

      cnt_d    = cnt_q;
      lvl_d    = lvl_q;
      pclk_d   = pclk_q;
      state_d  = state_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      rz_d     = 1'b0;
      pstop_d  = 1'b0;
      pstart_d = pause_rise & ~generation_en_i[ch];

      if (init_i[ch]) begin
        lvl_d   = starting_polarity_i[ch];
        cnt_d   = phase_offset_i[ch];
        pclk_d  = starting_polarity_i[ch];
        state_d = ACTIVE;
      end else begin
        if (toggle) begin
          lvl_d  = new_lvl;
          rise_d = new_lvl;
          fall_d = ~new_lvl;
          // A zero rate behaves as a one-cycle phase.
          if (rate == '0) begin
            cnt_d = '0;
            rz_d  = 1'b1;
          end else begin
            cnt_d = rate - RATE_ONE;
          end
        end else if (generation_en_i[ch]) begin
          cnt_d = cnt_q - RATE_ONE;
        end

        case (state_q)
          ACTIVE: begin
            pclk_d = lvl_d;
            if (pause_en_i[ch]) state_d = PAUSE_PENDING;
          end
          PAUSE_PENDING: begin
            pclk_d = lvl_d;
            if (!pause_en_i[ch]) begin
              state_d = ACTIVE;
              pstop_d = pause_fall;
            end else if (toggle && (new_lvl == pause_polarity_i[ch])) begin
              state_d = PAUSED;
            end
          end
          PAUSED: begin
            if (!pause_en_i[ch]) state_d = RESUME_PENDING;
          end
          RESUME_PENDING: begin
            if (pause_en_i[ch]) begin
              state_d = PAUSED;
            end else if (toggle && (new_lvl != pause_polarity_i[ch])) begin
              pclk_d  = new_lvl;
              state_d = ACTIVE;
            end
          end
          default: state_d = ACTIVE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge async_rst_i) begin
      if (async_rst_i) begin
        cnt_q    <= '0;
        lvl_q    <= 1'b0;
        pclk_q   <= 1'b0;
        state_q  <= ACTIVE;
        pause_q  <= 1'b0;
        paused_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        rz_q     <= 1'b0;
        pstart_q <= 1'b0;
        pstop_q  <= 1'b0;
      end else if (clk_en) begin
        cnt_q    <= cnt_d;
        lvl_q    <= lvl_d;
        pclk_q   <= pclk_d;
        state_q  <= state_d;
        pause_q  <= pause_en_i[ch];
        paused_q <= (state_d == PAUSED);
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        rz_q     <= rz_d;
        pstart_q <= pstart_d;
        pstop_q  <= pstop_d;
      end else begin
        // Held state, but strobes must not stretch across disabled cycles.
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        rz_q     <= 1'b0;
        pstart_q <= 1'b0;
        pstop_q  <= 1'b0;
      end
    end

    assign clk_o[ch]                   = lvl_q;
    assign pausable_clk_o[ch]          = pclk_q;
    assign rising_o[ch]                = rise_q;
    assign falling_o[ch]               = fall_q;
    assign paused_o[ch]                = paused_q;
    assign rate_zero_violation_o[ch]   = rz_q;
    assign pause_start_violation_o[ch] = pstart_q;
    assign pause_stop_violation_o[ch]  = pstop_q;
  end

endmodule

// File: tb/tb_multi_clock_generation.sv
// Scoreboard bench for multi_clock_generation: stimulus queues per-cycle
// expected output bits, a negedge monitor pops and compares them.
module tb_multi_clock_generation;

  localparam int CH = 4;
  localparam int RW = 8;

  localparam int S_CLK = 0, S_PCLK = 1, S_RISE = 2, S_FALL = 3;
  localparam int S_PAUSED = 4, S_RZ = 5, S_PSTART = 6, S_PSTOP = 7;

  logic clk;
  logic clk_en;
  logic async_rst;
  common_p::clk_dom_s sys_dom;
  logic [CH-1:0]         gen_en, init, start_pol, pause_en, pause_pol;
  logic [CH-1:0][RW-1:0] phase_offset, high_rate, low_rate;
  logic [CH-1:0]         clk_o, pclk_o, rising, falling, paused, rz_v, pstart_v, pstop_v;

  assign sys_dom = {clk, clk_en, 1'b0};

  multi_clock_generation #(.CHANNELS(CH), .RATE_WIDTH(RW)) dut (
    .sys_dom_i               (sys_dom),
    .async_rst_i             (async_rst),
    .generation_en_i         (gen_en),
    .init_i                  (init),
    .starting_polarity_i     (start_pol),
    .phase_offset_i          (phase_offset),
    .high_rate_i             (high_rate),
    .low_rate_i              (low_rate),
    .pause_en_i              (pause_en),
    .pause_polarity_i        (pause_pol),
    .clk_o                   (clk_o),
    .pausable_clk_o          (pclk_o),
    .rising_o                (rising),
    .falling_o               (falling),
    .paused_o                (paused),
    .rate_zero_violation_o   (rz_v),
    .pause_start_violation_o (pstart_v),
    .pause_stop_violation_o  (pstop_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   ch;
    int   sig;
    logic val;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string sig_name[8] = '{"clk", "pclk", "rising", "falling", "paused",
                         "rate_zero_viol", "pause_start_viol", "pause_stop_viol"};

  function automatic void push(int c, int ch, int sig, logic v);
    exp_t e;
    e.cyc = c; e.ch = ch; e.sig = sig; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic logic obs(int ch, int sig);
    case (sig)
      S_CLK:    return clk_o[ch];
      S_PCLK:   return pclk_o[ch];
      S_RISE:   return rising[ch];
      S_FALL:   return falling[ch];
      S_PAUSED: return paused[ch];
      S_RZ:     return rz_v[ch];
      S_PSTART: return pstart_v[ch];
      default:  return pstop_v[ch];
    endcase
  endfunction

  // Ideal waveform starting low, first rising edge visible at cycle 'first'.
  function automatic logic wv(int k, int first, int hi, int lo);
    if (k < first) return 1'b0;
    return logic'(((k - first) % (hi + lo)) < hi);
  endfunction

  function automatic void push_wave(int c0, int ch, int first, int hi, int lo,
                                    int kmax, bit with_pclk);
    for (int k = 1; k <= kmax; k++) begin
      int d;
      d = k - first;
      push(c0 + k, ch, S_CLK, wv(k, first, hi, lo));
      if (with_pclk) push(c0 + k, ch, S_PCLK, wv(k, first, hi, lo));
      push(c0 + k, ch, S_RISE, logic'(d >= 0 && (d % (hi + lo)) == 0));
      push(c0 + k, ch, S_FALL, logic'(d >= 0 && (d % (hi + lo)) == hi));
    end
  endfunction

  function automatic void push_all_zero(int c);
    for (int ch = 0; ch < CH; ch++)
      for (int s = 0; s < 8; s++) push(c, ch, s, 1'b0);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic a;
        a = obs(sb[i].ch, sb[i].sig);
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s ch%0d: expectation for cycle %0d was never sampled (now %0d)",
                   sig_name[sb[i].sig], sb[i].ch, sb[i].cyc, cyc);
        end else if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s ch%0d cycle %0d: got %b, expected %b",
                   sig_name[sb[i].sig], sb[i].ch, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic nxt(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(int ch, int hi, int lo, int off, logic pol, logic ppol);
    high_rate[ch]    = RW'(hi);
    low_rate[ch]     = RW'(lo);
    phase_offset[ch] = RW'(off);
    start_pol[ch]    = pol;
    pause_pol[ch]    = ppol;
    init[ch]         = 1'b1;
    gen_en[ch]       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic ch3_clk[12];
    async_rst    = 1'b1;
    clk_en       = 1'b1;
    gen_en       = '0;
    init         = '0;
    start_pol    = '0;
    pause_en     = '0;
    pause_pol    = '0;
    phase_offset = '0;
    high_rate    = '0;
    low_rate     = '0;

    // Reset state
    @(negedge clk);
    push_all_zero(cyc + 1);
    nxt(1);
    #1 async_rst = 1'b0;

    // Basic periods: 3 high / 2 low
    nxt(1); c0 = cyc;
    setup(0, 3, 2, 0, 1'b0, 1'b0);
    push_wave(c0, 0, 2, 3, 2, 16, 1'b1);
    nxt(1); init = '0;
    nxt(16);

    // Phase offsets 0..3 on four channels at 4/4
    c0 = cyc;
    for (int i = 0; i < CH; i++) begin
      setup(i, 4, 4, i, 1'b0, 1'b0);
      push_wave(c0, i, 2 + i, 4, 4, 20, 1'b1);
    end
    nxt(1); init = '0;
    nxt(20);

    // Pause high on ch0 at 2/2, requested mid-low-phase
    c0 = cyc;
    setup(0, 2, 2, 0, 1'b0, 1'b1);
    push_wave(c0, 0, 2, 2, 2, 16, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      push(c0 + k, 0, S_PCLK, (k >= 6 && k <= 11) ? 1'b1 : wv(k, 2, 2, 2));
      push(c0 + k, 0, S_PAUSED, logic'(k >= 6 && k <= 9));
    end
    push(c0 + 5, 0, S_PSTART, 1'b0);
    nxt(1); init = '0;
    nxt(3); pause_en[0] = 1'b1;
    nxt(5); pause_en[0] = 1'b0;
    nxt(7);

    // Pause withdrawn during a 4-cycle high phase on ch1
    c0 = cyc;
    setup(1, 4, 2, 0, 1'b0, 1'b0);
    push_wave(c0, 1, 2, 4, 2, 14, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      push(c0 + k, 1, S_PSTOP, logic'(k == 4));
      push(c0 + k, 1, S_PAUSED, 1'b0);
    end
    nxt(1); init = '0;
    nxt(1); pause_en[1] = 1'b1;
    nxt(1); pause_en[1] = 1'b0;
    nxt(11);

    // Zero high rate on ch2; low rate 5 -> 2 mid-phase on ch3
    c0 = cyc;
    setup(2, 0, 2, 0, 1'b0, 1'b0);
    setup(3, 1, 5, 0, 1'b0, 1'b0);
    push_wave(c0, 2, 2, 1, 2, 10, 1'b1);
    for (int k = 1; k <= 10; k++)
      push(c0 + k, 2, S_RZ, logic'(k >= 2 && ((k - 2) % 3) == 0));
    ch3_clk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 12; k++) begin
      push(c0 + k, 3, S_CLK, ch3_clk[k - 1]);
      push(c0 + k, 3, S_RZ, 1'b0);
    end
    nxt(1); init = '0;
    nxt(3); low_rate[3] = RW'(2);
    nxt(8);

    // Pause request while ch2 is disabled still advances the FSM
    c0 = cyc;
    setup(2, 2, 2, 0, 1'b0, 1'b1);
    push(c0 + 1, 2, S_PSTART, 1'b0);
    push(c0 + 2, 2, S_PSTART, 1'b1);
    push(c0 + 3, 2, S_PSTART, 1'b0);
    push(c0 + 2, 2, S_PAUSED, 1'b0);
    push(c0 + 3, 2, S_PAUSED, 1'b1);
    push(c0 + 4, 2, S_PAUSED, 1'b1);
    push(c0 + 2, 2, S_PCLK, 1'b0);
    push(c0 + 3, 2, S_PCLK, 1'b1);
    push(c0 + 2, 2, S_CLK, 1'b0);
    push(c0 + 3, 2, S_CLK, 1'b1);
    push(c0 + 3, 2, S_RISE, 1'b1);
    nxt(1); init = '0; gen_en[2] = 1'b0; pause_en[2] = 1'b1;
    nxt(1); gen_en[2] = 1'b1;
    nxt(3); pause_en[2] = 1'b0;

    // clk_en freeze for 10 cycles on ch0 at 3/2, then async reset
    nxt(1); c0 = cyc;
    setup(0, 3, 2, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      logic cv;
      cv = logic'((k >= 2 && k <= 14) || k >= 17);
      push(c0 + k, 0, S_CLK, cv);
      push(c0 + k, 0, S_PCLK, cv);
      push(c0 + k, 0, S_RISE, logic'(k == 2 || k == 17));
      push(c0 + k, 0, S_FALL, logic'(k == 15));
    end
    nxt(1); init = '0;
    nxt(1); clk_en = 1'b0;
    nxt(10); clk_en = 1'b1;
    nxt(6);
    gen_en = '0;
    push_all_zero(cyc + 1);
    push_all_zero(cyc + 2);
    @(posedge clk);
    #1 async_rst = 1'b1;
    @(negedge clk);
    #2 async_rst = 1'b0;
    nxt(3);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s ch%0d: expectation for cycle %0d left unchecked",
               sig_name[sb[0].sig], sb[0].ch, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
